// File: rtl/apb3_requester.sv
// APB3 requester: turns single valid/ready commands into one APB3 SETUP/ACCESS
// transfer each, with a programmable PREADY wait-state timeout.
module apb3_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  abort;

  // Last permitted wait cycle with PREADY still low; PREADY on this edge wins.
  assign abort = TO_EN && !PREADY && (cnt_q == CNT_LAST);

  // State and output registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && cmd_ready_q) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || abort) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else if (abort) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb3_requester.sv
// Self-checking bench for apb3_requester: a TIMEOUT=4 instance (dut) and a
// TIMEOUT=0 instance (dut0) share all inputs; expectations come from transfer-level rules.
module tb_apb3_requester;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata, PRDATA;
  logic        PREADY, PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic        cmd_ready0, rsp_valid0, rsp_err0, PSEL0, PENABLE0, PWRITE0;
  logic [31:0] rsp_rdata0, PADDR0, PWDATA0;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_xfer call.
  int          obs_lat, obs_psel, obs_pen;
  logic        obs_proto, obs_unstable, obs_busy, obs_after_ready, obs_after_valid, obs_err;
  logic [31:0] obs_rdata;

  always #5 PCLK = ~PCLK;

  apb3_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb3_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .PADDR(PADDR0), .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PWDATA(PWDATA0),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Emulates a completer for one transfer on dut and records what was observed.
  // Enters and leaves just after a falling edge.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prd, input logic slv,
                          input int rsp_wait, input logic hold_valid);
    int acc = 0;
    int n = 0;
    obs_lat = -1; obs_psel = 0; obs_pen = 0; obs_proto = 1'b0; obs_unstable = 1'b0;
    obs_busy = 1'b0; obs_after_ready = 1'b0; obs_after_valid = 1'b1;
    obs_err = 1'b0; obs_rdata = '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    for (int k = 1; k <= 200; k++) begin
      if (rsp_valid) begin
        obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err;
        if (PSEL || PENABLE) obs_proto = 1'b1;
        break;
      end
      if (PENABLE && !PSEL) obs_proto = 1'b1;
      if (PSEL) begin
        obs_psel++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) obs_proto = 1'b1;
      end
      if (PSEL && PENABLE) begin
        obs_pen++;
        PREADY  = (acc >= waits);
        PSLVERR = PREADY ? slv : 1'($urandom);
        PRDATA  = PREADY ? prd : $urandom;
        acc++;
      end else begin
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      @(negedge PCLK);
    end
    if (obs_lat < 0) return;
    cmd_valid = hold_valid;
    for (int j = 0; j < rsp_wait; j++) begin
      rsp_ready = 1'b0;
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err) obs_unstable = 1'b1;
      if (cmd_ready || PSEL) obs_busy = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    obs_after_ready = cmd_ready; obs_after_valid = rsp_valid;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
    rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b paddr=%h pwdata=%h rdata=%h exp all 0",
               {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, PADDR, PWDATA, rsp_rdata);
    end
    checks++;
    if ({cmd_ready0, PSEL0, PENABLE0, rsp_valid0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs_t0 got %b exp 0000", {cmd_ready0, PSEL0, PENABLE0, rsp_valid0});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1 || PSEL !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b psel=%b rv=%b exp 1 0 0", cmd_ready, PSEL, rsp_valid);
    end
  endtask

  task automatic test_zero_wait_write();
    run_xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 1'b0);
    checks++;
    if (obs_lat !== 3 || obs_psel !== 2 || obs_pen !== 1) begin
      errors++;
      $display("FAIL zw_timing got lat=%0d psel=%0d pen=%0d exp 3 2 1", obs_lat, obs_psel, obs_pen);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'h0 || obs_proto !== 1'b0) begin
      errors++;
      $display("FAIL zw_resp got err=%b rdata=%h proto=%b exp 0 0 0", obs_err, obs_rdata, obs_proto);
    end
    checks++;
    if (obs_after_ready !== 1'b1 || obs_after_valid !== 1'b0) begin
      errors++;
      $display("FAIL zw_return got rdy=%b rv=%b exp 1 0", obs_after_ready, obs_after_valid);
    end
  endtask

  task automatic test_wait_read();
    run_xfer(1'b0, 32'h10, $urandom, 3, 32'h12345678, 1'b0, 0, 1'b0);
    checks++;
    if (obs_lat !== 6 || obs_pen !== 4 || obs_psel !== 5) begin
      errors++;
      $display("FAIL wait_timing got lat=%0d pen=%0d psel=%0d exp 6 4 5", obs_lat, obs_pen, obs_psel);
    end
    checks++;
    if (obs_rdata !== 32'h12345678 || obs_err !== 1'b0 || obs_proto !== 1'b0) begin
      errors++;
      $display("FAIL wait_resp got rdata=%h err=%b proto=%b exp 12345678 0 0", obs_rdata, obs_err, obs_proto);
    end
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 32'h40, $urandom, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    checks++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 3) begin
      errors++;
      $display("FAIL slverr got err=%b rdata=%h lat=%0d exp 1 0 3", obs_err, obs_rdata, obs_lat);
    end
  endtask

  task automatic test_backpressure();
    run_xfer(1'b0, 32'h8, $urandom, 1, 32'hA5A5_0F0F, 1'b0, 5, 1'b1);
    checks++;
    if (obs_unstable !== 1'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got unstable=%b busy=%b exp 0 0", obs_unstable, obs_busy);
    end
    checks++;
    if (obs_rdata !== 32'hA5A5_0F0F || obs_after_ready !== 1'b1 || obs_after_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdata=%h rdy=%b rv=%b exp a5a50f0f 1 0",
               obs_rdata, obs_after_ready, obs_after_valid);
    end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h20, $urandom, 10, 32'h55AA55AA, 1'b0, 0, 1'b0);
    checks++;
    if (obs_pen !== TO || obs_lat !== TO + 2 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_abort got pen=%0d lat=%0d err=%b rdata=%h exp %0d %0d 1 0",
               obs_pen, obs_lat, obs_err, obs_rdata, TO, TO + 2);
    end
    run_xfer(1'b0, 32'h24, $urandom, TO - 1, 32'h0BADF00D, 1'b0, 0, 1'b0);
    checks++;
    if (obs_pen !== TO || obs_err !== 1'b0 || obs_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL timeout_edge got pen=%0d err=%b rdata=%h exp %0d 0 0badf00d",
               obs_pen, obs_err, obs_rdata, TO);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic        wr, slv, aborted, exp_err;
      logic [31:0] addr, wdata, prd, exp_rd;
      int          waits, rw, exp_pen;
      wr = 1'($urandom); slv = ($urandom_range(0, 3) == 0);
      addr = $urandom; wdata = $urandom; prd = $urandom;
      waits = $urandom_range(0, 6); rw = $urandom_range(0, 3);
      aborted = (waits >= TO);
      exp_pen = aborted ? TO : waits + 1;
      exp_err = aborted || slv;
      exp_rd  = (exp_err || wr) ? 32'h0 : prd;
      run_xfer(wr, addr, wdata, waits, prd, slv, rw, 1'($urandom));
      checks++;
      if (obs_lat !== exp_pen + 2 || obs_pen !== exp_pen || obs_psel !== exp_pen + 1) begin
        errors++;
        $display("FAIL rand_timing[%0d] got lat=%0d pen=%0d psel=%0d exp %0d %0d %0d",
                 i, obs_lat, obs_pen, obs_psel, exp_pen + 2, exp_pen, exp_pen + 1);
      end
      checks++;
      if (obs_rdata !== exp_rd || obs_err !== exp_err) begin
        errors++;
        $display("FAIL rand_resp[%0d] got rdata=%h err=%b exp %h %b", i, obs_rdata, obs_err, exp_rd, exp_err);
      end
      checks++;
      if (obs_proto || obs_unstable || obs_busy || !obs_after_ready || obs_after_valid) begin
        errors++;
        $display("FAIL rand_proto[%0d] got proto=%b unst=%b busy=%b rdy=%b rv=%b exp 0 0 0 1 0",
                 i, obs_proto, obs_unstable, obs_busy, obs_after_ready, obs_after_valid);
      end
    end
  endtask

  // Both instances see PREADY low for 100 ACCESS cycles; only the TIMEOUT=4 one may abort.
  task automatic test_no_timeout();
    int n = 0;
    logic bad = 1'b0;
    do_reset();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = $urandom;
    PREADY = 1'b0; rsp_ready = 1'b0;
    while (!cmd_ready0 && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    for (int i = 0; i < 100; i++) begin
      if (!(PSEL0 && PENABLE0) || rsp_valid0) bad = 1'b1;
      PREADY = 1'b0; PRDATA = $urandom;
      @(negedge PCLK);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_hold got early_exit=%b exp 0", bad);
    end
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hC0FFEE00;
    @(negedge PCLK);
    PREADY = 1'b0;
    checks++;
    if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'hC0FFEE00 || rsp_err0 !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_resp got rv=%b rdata=%h err=%b exp 1 c0ffee00 0", rsp_valid0, rsp_rdata0, rsp_err0);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_parked got rv=%b err=%b rdata=%h exp 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready0 !== 1'b1 || rsp_valid !== 1'b0 || rsp_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_return got rdy=%b rdy0=%b rv=%b rv0=%b exp 1 1 0 0",
               cmd_ready, cmd_ready0, rsp_valid, rsp_valid0);
    end
  endtask

  task automatic test_reset_in_access();
    int n = 0;
    logic stale = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h12121212; PREADY = 1'b0;
    while (!cmd_ready && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc_setup got psel=%b pen=%b exp 1 1", PSEL, PENABLE);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || {PSEL0, PENABLE0} !== 2'b0) begin
      errors++;
      $display("FAIL rst_acc_clear got ctl=%b paddr=%h pwdata=%h exp all 0",
               {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, PADDR, PWDATA);
    end
    PRESETn = 1'b1; rsp_ready = 1'b1; PREADY = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_release got rdy=%b rv=%b exp 1 0", cmd_ready, rsp_valid);
    end
    repeat (8) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL || rsp_valid0 || PSEL0) stale = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_stale got stale=%b exp 0", stale);
    end
    run_xfer(1'b0, 32'h48, $urandom, 0, 32'h600DCAFE, 1'b0, 0, 1'b0);
    checks++;
    if (obs_lat !== 3 || obs_rdata !== 32'h600DCAFE || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_resume got lat=%0d rdata=%h err=%b exp 3 600dcafe 0", obs_lat, obs_rdata, obs_err);
    end
  endtask

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_backpressure();
    test_timeout();
    test_random();
    test_no_timeout();
    test_reset_in_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
